// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Bits needed for an iteration counter that runs 0 .. w-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the ALU and the sequential multiplier.
interface seq_multiplier_if #(parameter int WIDTH = 8);

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_multiplier_add_n.sv
// Parametrised ripple-carry adder built from the full-adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module add_n #(parameter int N = 9) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fulladder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock,
// signed operands handled as magnitudes with the sign applied at the end.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int ACC_W = 2 * WIDTH + 1;

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [2*WIDTH-1:0]   acc_neg;
  logic [WIDTH:0]       sum;
  logic                 carry;

  // The most negative operand negates to itself, which read unsigned is the
  // correct magnitude 2^(WIDTH-1).
  assign a_mag = (bus.signed_mode == MODE_SIGNED && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_mode == MODE_SIGNED && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  add_n #(.N(WIDTH + 1)) u_add (
    .x    (acc[ACC_W-1:WIDTH]),
    .y    ({1'b0, mcand}),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  assign acc_next = acc[0] ? {carry, sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[ACC_W-1:1]};
  assign acc_neg  = -acc[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= a_mag;
            acc    <= {{(WIDTH + 1){1'b0}}, b_mag};
            neg    <= (bus.signed_mode == MODE_SIGNED) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          product_r <= neg ? acc_neg : acc[2*WIDTH-1:0];
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH = 8.
module tb_seq_multiplier;

  localparam int WIDTH   = 8;
  localparam int LATENCY = WIDTH + 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; launches one multiply and returns at the
  // falling edge where done is seen (or the budget runs out).
  task automatic apply_stimulus(input string tag, input logic mode,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input bit disturb, input logic [2*WIDTH-1:0] expected);
    int n;
    int busy_cnt;
    bus.start       = 1'b1;
    bus.signed_mode = mode;
    bus.a           = a;
    bus.b           = b;
    @(posedge clk);
    n        = 1;
    busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      if (disturb) begin
        bus.start       = 1'b1;
        bus.signed_mode = ~bus.signed_mode;
        bus.a           = WIDTH'(n);
        bus.b           = WIDTH'(n * 3 + 1);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_output({tag, "_latency"}, n, LATENCY);
    check_output({tag, "_busy_cycles"}, busy_cnt, LATENCY - 1);
    check_output({tag, "_product"}, bus.product, expected);
    check_output({tag, "_busy_at_done"}, bus.busy, 1'b0);
  endtask

  task automatic check_hold(input string tag, input logic [2*WIDTH-1:0] expected);
    @(negedge clk);
    check_output({tag, "_done_low"}, bus.done, 1'b0);
    check_output({tag, "_busy_low"}, bus.busy, 1'b0);
    check_output({tag, "_product_hold"}, bus.product, expected);
  endtask

  initial begin
    int done_cnt;
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;

    repeat (2) @(negedge clk);
    check_output("reset_busy", bus.busy, 1'b0);
    check_output("reset_done", bus.done, 1'b0);
    check_output("reset_product", bus.product, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus("u255x255", 1'b0, 8'd255, 8'd255, 1'b0, 16'hFE01);
    check_hold("u255x255", 16'hFE01);

    apply_stimulus("s_m128xm128", 1'b1, 8'h80, 8'h80, 1'b0, 16'h4000);
    check_hold("s_m128xm128", 16'h4000);

    apply_stimulus("s_m3x5", 1'b1, 8'hFD, 8'd5, 1'b0, 16'hFFF1);
    check_hold("s_m3x5", 16'hFFF1);

    apply_stimulus("s_m128x1", 1'b1, 8'h80, 8'd1, 1'b0, 16'hFF80);
    check_hold("s_m128x1", 16'hFF80);

    apply_stimulus("s_7xm2", 1'b1, 8'd7, 8'hFE, 1'b0, 16'hFFF2);
    check_hold("s_7xm2", 16'hFFF2);

    apply_stimulus("u200x3", 1'b0, 8'd200, 8'd3, 1'b0, 16'h0258);
    check_hold("u200x3", 16'h0258);

    apply_stimulus("u0x200", 1'b0, 8'd0, 8'd200, 1'b0, 16'h0000);
    check_hold("u0x200", 16'h0000);

    // Inputs and start toggle while busy; only the captured operands count.
    apply_stimulus("u12x13_disturbed", 1'b0, 8'd12, 8'd13, 1'b1, 16'h009C);
    check_hold("u12x13_disturbed", 16'h009C);

    // Second request issued in the done cycle of the first.
    apply_stimulus("b2b_first", 1'b0, 8'd5, 8'd6, 1'b0, 16'h001E);
    apply_stimulus("b2b_7x9", 1'b0, 8'd7, 8'd9, 1'b0, 16'h003F);
    check_hold("b2b_7x9", 16'h003F);

    // Asynchronous reset in the middle of a run.
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.a           = 8'd100;
    bus.b           = 8'd100;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midrun_busy_before_reset", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_busy", bus.busy, 1'b0);
    check_output("async_reset_done", bus.done, 1'b0);
    check_output("async_reset_product", bus.product, 16'h0000);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_output("no_done_after_reset", done_cnt, 0);
    check_output("product_zero_after_reset", bus.product, 16'h0000);

    apply_stimulus("u10x11_after_reset", 1'b0, 8'd10, 8'd11, 1'b0, 16'h006E);
    check_hold("u10x11_after_reset", 16'h006E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
